// File: rtl/tool_gry_cvt_pipe_pkg.sv
// Shared types and helpers for the pipelined binary<->Gray converter.
// Holds the conversion-mode enum and the segment-width helper.
package tool_pkg;

    typedef enum logic {
        CVT_BIN2GRY = 1'b0,
        CVT_GRY2BIN = 1'b1
    } cvt_mode_e;

    function automatic int tool_seg_width(int w, int s);
        return (w + s - 1) / s;
    endfunction

endpackage

// File: rtl/tool_gry_cvt_pipe_stage.sv
// One register stage of the converter: resolves its slice of the Gray->binary
// prefix-XOR chain (and the whole binary->Gray step when FIRST); optional
// original-data register under TOOL_GRY_CVT_CHK_EN.
module tool_gry_cvt_stage
    import tool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int SEG_HI     = 31,
    parameter int SEG_LO     = 16,
    parameter int HAS_SEG    = 1,
    parameter int FIRST      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  in_valid,
    input  logic                  in_mode,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]  in_tag,
`ifdef TOOL_GRY_CVT_CHK_EN
    input  logic [DATA_WIDTH-1:0] in_orig,
    output logic [DATA_WIDTH-1:0] out_orig,
`endif
    output logic                  out_valid,
    output logic                  out_mode,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    logic                  valid_d, valid_q;
    logic                  mode_d, mode_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic [TAG_WIDTH-1:0]  tag_d, tag_q;
    logic [DATA_WIDTH-1:0] conv_s;
`ifdef TOOL_GRY_CVT_CHK_EN
    logic [DATA_WIDTH-1:0] orig_d, orig_q;
`endif

    // Bits above SEG_HI arrive already resolved, so the chain starts from in_data[SEG_HI+1].
    always_comb begin
        conv_s = in_data;
        if ((FIRST != 0) && (in_mode == CVT_BIN2GRY)) begin
            conv_s = in_data ^ (in_data >> 1);
        end else if ((HAS_SEG != 0) && (in_mode == CVT_GRY2BIN)) begin
            for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
                if ((i <= SEG_HI) && (i >= SEG_LO)) begin
                    conv_s[i] = conv_s[i+1] ^ in_data[i];
                end else begin
                    conv_s[i] = conv_s[i];
                end
            end
        end else begin
            conv_s = in_data;
        end
    end

    // Next-state: capture the upstream beat (or a bubble) whenever this stage may advance.
    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        data_d  = data_q;
        tag_d   = tag_q;
`ifdef TOOL_GRY_CVT_CHK_EN
        orig_d  = orig_q;
`endif
        if (load) begin
            valid_d = in_valid;
            mode_d  = in_mode;
            data_d  = conv_s;
            tag_d   = in_tag;
`ifdef TOOL_GRY_CVT_CHK_EN
            orig_d  = in_orig;
`endif
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            data_q  <= {DATA_WIDTH{1'b0}};
            tag_q   <= {TAG_WIDTH{1'b0}};
`ifdef TOOL_GRY_CVT_CHK_EN
            orig_q  <= {DATA_WIDTH{1'b0}};
`endif
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
`ifdef TOOL_GRY_CVT_CHK_EN
            orig_q  <= orig_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_mode  = mode_q;
    assign out_data  = data_q;
    assign out_tag   = tag_q;
`ifdef TOOL_GRY_CVT_CHK_EN
    assign out_orig  = orig_q;
`endif

endmodule

// File: rtl/tool_gry_cvt_pipe.sv
// Pipelined bidirectional binary<->Gray converter with valid/ready and a per-beat tag.
// Optional round-trip self-check enabled by macro TOOL_GRY_CVT_CHK_EN.
module tool_gry_cvt_pipe
    import tool_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_mode,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic                  o_chk_err
);

    localparam int SEG = tool_seg_width(DATA_WIDTH, PIPE_STAGES);

    // Index 0 is the input port; index s+1 is the register output of stage s.
    logic [PIPE_STAGES:0]  vld_s;
    logic [PIPE_STAGES:0]  mode_s;
    logic [PIPE_STAGES:0]  rdy_s;
    logic [DATA_WIDTH-1:0] data_s [PIPE_STAGES+1];
    logic [TAG_WIDTH-1:0]  tag_s  [PIPE_STAGES+1];
`ifdef TOOL_GRY_CVT_CHK_EN
    logic [DATA_WIDTH-1:0] orig_s [PIPE_STAGES+1];
    assign orig_s[0] = i_data;
`endif

    assign vld_s[0]  = i_valid;
    assign mode_s[0] = i_mode;
    assign data_s[0] = i_data;
    assign tag_s[0]  = i_tag;

    // Ready chain: a stage may advance when it is empty or its successor advances.
    always_comb begin
        rdy_s              = {(PIPE_STAGES+1){1'b0}};
        rdy_s[PIPE_STAGES] = i_ready;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            rdy_s[s] = !vld_s[s+1] || rdy_s[s+1];
        end
    end

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int HI_RAW = DATA_WIDTH - 1 - s * SEG;
        localparam int HAS    = (HI_RAW >= 0) ? 1 : 0;
        localparam int HI     = (HI_RAW >= 0) ? HI_RAW : 0;
        localparam int LO     = (HI_RAW - SEG + 1 > 0) ? (HI_RAW - SEG + 1) : 0;

        tool_gry_cvt_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH),
            .SEG_HI     (HI),
            .SEG_LO     (LO),
            .HAS_SEG    (HAS),
            .FIRST      ((s == 0) ? 1 : 0)
        ) u_stage (
            .clk       (i_clk),
            .rst       (i_rst),
            .load      (rdy_s[s]),
            .in_valid  (vld_s[s]),
            .in_mode   (mode_s[s]),
            .in_data   (data_s[s]),
            .in_tag    (tag_s[s]),
`ifdef TOOL_GRY_CVT_CHK_EN
            .in_orig   (orig_s[s]),
            .out_orig  (orig_s[s+1]),
`endif
            .out_valid (vld_s[s+1]),
            .out_mode  (mode_s[s+1]),
            .out_data  (data_s[s+1]),
            .out_tag   (tag_s[s+1])
        );
    end

    assign o_ready = rdy_s[0];
    assign o_valid = vld_s[PIPE_STAGES];
    assign o_data  = data_s[PIPE_STAGES];
    assign o_tag   = tag_s[PIPE_STAGES];

`ifdef TOOL_GRY_CVT_CHK_EN
    function automatic logic [DATA_WIDTH-1:0] f_bin2gry(input logic [DATA_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_gry2bin(input logic [DATA_WIDTH-1:0] g);
        logic [DATA_WIDTH-1:0] b;
        b = g;
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] recon_s;

    // Re-convert the output the opposite way and flag a mismatch on the transfer cycle.
    always_comb begin
        if (mode_s[PIPE_STAGES] == CVT_GRY2BIN) begin
            recon_s = f_bin2gry(o_data);
        end else begin
            recon_s = f_gry2bin(o_data);
        end
        o_chk_err = o_valid && i_ready && (recon_s != orig_s[PIPE_STAGES]);
    end
`else
    assign o_chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_tool_gry_cvt_pipe.sv
// Self-checking bench: table vectors, reset/stall sequences, random stream vs
// a reference model, and an exhaustive 8-bit sweep at 1, 3 and 8 stages.
module tb_tool_gry_cvt_pipe;
    import tool_pkg::*;

    localparam int W = 32;
    localparam int S = 2;
    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, i_valid, o_ready, i_mode, i_ready, o_valid, o_chk_err;
    logic [W-1:0] i_data, o_data;
    logic [T-1:0] i_tag, o_tag;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    tool_gry_cvt_pipe #(.DATA_WIDTH(W), .PIPE_STAGES(S), .TAG_WIDTH(T)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
        .i_data(i_data), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_tag(o_tag), .o_chk_err(o_chk_err)
    );

    // Reference model from the arithmetic definition of Gray code.
    function automatic logic [31:0] ref_b2g(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] ref_g2b(input logic [31:0] g);
        logic [31:0] b;
        b = 32'h0;
        for (int i = 0; i < 32; i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic logic [31:0] ref_cvt(input logic m, input logic [31:0] x);
        return m ? ref_g2b(x) : ref_b2g(x);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and monitor for the main instance.
    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int          acc;
    } sb_t;

    sb_t          sbq[$];
    logic [31:0]  drv_exp;
    bit           mon_on  = 1'b0;
    bit           lat_chk = 1'b0;
    bit           prev_stall = 1'b0;
    logic [31:0]  prev_d;
    logic [3:0]   prev_t;

    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            sbq.delete();
            prev_stall = 1'b0;
        end else if (mon_on) begin
            if (prev_stall) begin
                check("hold_valid", {31'h0, o_valid}, 32'h1);
                check("hold_data", o_data, prev_d);
                check("hold_tag", {28'h0, o_tag}, {28'h0, prev_t});
            end
            check("o_ready", {31'h0, o_ready}, {31'h0, !((sbq.size() == S) && !i_ready)});
            check("chk_err_idle", {31'h0, o_chk_err}, 32'h0);
            if (o_valid && i_ready) begin
                if (sbq.size() == 0) begin
                    check("spurious_beat", {31'h0, o_valid}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    check("out_data", o_data, e.data);
                    check("out_tag", {28'h0, o_tag}, {28'h0, e.tag});
                    if (lat_chk) check("latency", cyc - e.acc, S);
                end
            end
            if (i_valid && o_ready) sbq.push_back('{drv_exp, i_tag, cyc});
            prev_stall = o_valid && !i_ready;
            prev_d     = o_data;
            prev_t     = o_tag;
        end
    end

    task automatic send(input logic m, input logic [31:0] d, input logic [3:0] t, input logic [31:0] e);
        int k;
        i_valid = 1'b1; i_mode = m; i_data = d; i_tag = t; drv_exp = e;
        k = 0;
        @(negedge clk);
        while (!o_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!o_ready) check("accept_timeout", {31'h0, o_ready}, 32'h1);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain", sbq.size(), 0);
    endtask

    // Exhaustive 8-bit sweep: three extra instances, expectation derived from beat index.
    logic       sw_on = 1'b0;
    int         sw_base = 0;
    logic       sw_valid = 1'b0, sw_mode = 1'b0;
    logic [7:0] sw_data = 8'h0;
    logic [3:0] sw_tag = 4'h0;

    for (genvar k = 0; k < 3; k++) begin : g_sw
        localparam int SV = (k == 0) ? 1 : ((k == 1) ? 3 : 8);
        logic       ov, ordy, ce;
        logic [7:0] od;
        logic [3:0] ot;

        tool_gry_cvt_pipe #(.DATA_WIDTH(8), .PIPE_STAGES(SV), .TAG_WIDTH(4)) u_sw (
            .i_clk(clk), .i_rst(rst), .i_valid(sw_valid), .o_ready(ordy), .i_mode(sw_mode),
            .i_data(sw_data), .i_tag(sw_tag), .o_valid(ov), .i_ready(1'b1),
            .o_data(od), .o_tag(ot), .o_chk_err(ce)
        );

        always @(negedge clk) begin
            int t;
            if (sw_on && !rst) begin
                t = cyc - sw_base - SV;
                if (t >= 0 && t < 512) begin
                    check($sformatf("sw_s%0d_valid", SV), {31'h0, ov}, 32'h1);
                    check($sformatf("sw_s%0d_data", SV), {24'h0, od}, ref_cvt(t >= 256, t & 255));
                    check($sformatf("sw_s%0d_tag", SV), {28'h0, ot}, t & 15);
                end else begin
                    check($sformatf("sw_s%0d_idle", SV), {31'h0, ov}, 32'h0);
                end
                check($sformatf("sw_s%0d_ready", SV), {31'h0, ordy}, 32'h1);
            end
        end
    end

    typedef struct {
        logic        mode;
        logic [31:0] data;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t       vt[6];
    bit         done;
    logic [3:0] pat = 4'b1001;

    initial begin
        vt[0] = '{1'b1, 32'h8000_0000, 4'h1, 32'hFFFF_FFFF};
        vt[1] = '{1'b0, 32'h0000_0005, 4'h2, 32'h0000_0007};
        vt[2] = '{1'b0, 32'h0000_0000, 4'h3, 32'h0000_0000};
        vt[3] = '{1'b1, 32'h0000_0000, 4'h4, 32'h0000_0000};
        vt[4] = '{1'b0, 32'hFFFF_FFFF, 4'h5, 32'h8000_0000};
        vt[5] = '{1'b1, 32'hFFFF_FFFF, 4'h6, 32'hAAAA_AAAA};

        rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_data = '0; i_tag = '0; i_ready = 1'b1;
        drv_exp = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_o_valid", {31'h0, o_valid}, 32'h0);
        check("rst_o_data", o_data, 32'h0);
        check("rst_o_tag", {28'h0, o_tag}, 32'h0);
        check("rst_o_chk_err", {31'h0, o_chk_err}, 32'h0);
        check("rst_o_ready", {31'h0, o_ready}, 32'h1);
        mon_on = 1'b1;
        @(posedge clk); #1;

        // Table vectors back to back with latency checking.
        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) send(vt[i].mode, vt[i].data, vt[i].tag, vt[i].exp);
        drain();
        lat_chk = 1'b0;

        // Reset with two beats in flight.
        i_ready = 1'b0;
        send(1'b0, 32'h1234_5678, 4'hA, ref_cvt(1'b0, 32'h1234_5678));
        send(1'b1, 32'h0F0F_0F0F, 4'hB, ref_cvt(1'b1, 32'h0F0F_0F0F));
        rst = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_o_valid", {31'h0, o_valid}, 32'h0);
        check("midrst_o_ready", {31'h0, o_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_quiet", {31'h0, o_valid}, 32'h0);
        end
        @(posedge clk); #1;

        // Ten beats while i_ready cycles 1,0,0,1.
        done = 1'b0;
        fork
            begin
                logic [31:0] d;
                logic        m;
                for (int i = 0; i < 10; i++) begin
                    d = $urandom;
                    m = 1'($urandom_range(0, 1));
                    send(m, d, 4'(i), ref_cvt(m, d));
                end
                drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    i_ready = pat[cyc % 4];
                end
            end
        join
        i_ready = 1'b1;

        // Random stream with random gaps and random backpressure.
        done = 1'b0;
        fork
            begin
                logic [31:0] d;
                logic        m;
                for (int i = 0; i < 150; i++) begin
                    d = $urandom;
                    m = 1'($urandom_range(0, 1));
                    send(m, d, 4'($urandom_range(0, 15)), ref_cvt(m, d));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                i_ready = 1'b1;
                drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    if (!done) i_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        i_ready = 1'b1;

`ifdef TOOL_GRY_CVT_CHK_EN
        // Corrupt the output-stage data of a parked beat; the check must pulse once.
        mon_on = 1'b0;
        i_ready = 1'b0;
        send(1'b0, 32'h0000_0005, 4'h3, 32'h0000_0007);
        @(posedge clk); #1;
        force dut.g_stage[S-1].u_stage.data_q = 32'h0000_0006;
        i_ready = 1'b1;
        @(negedge clk);
        check("chk_err_pulse", {31'h0, o_chk_err}, 32'h1);
        @(posedge clk); #1;
        release dut.g_stage[S-1].u_stage.data_q;
        @(negedge clk);
        check("chk_err_clear", {31'h0, o_chk_err}, 32'h0);
        @(posedge clk); #1;
        mon_on = 1'b1;
`endif

        // Exhaustive sweep for the 8-bit instances.
        sw_base = cyc;
        sw_on   = 1'b1;
        for (int t = 0; t < 512; t++) begin
            sw_valid = 1'b1;
            sw_mode  = (t >= 256);
            sw_data  = 8'(t);
            sw_tag   = 4'(t);
            @(posedge clk); #1;
        end
        sw_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 sw_on = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
